// File: rtl/deconcater_loader.sv
// rtl/deconcater_loader.sv - splits a 32-bit word into six fields and writes them serially into six banks
// Optional feature macro: DECONCAT_PARITY_EN (adds in_par input and sticky par_err output).
module deconcater_loader #(
    parameter int F1_W = 8,
    parameter int F2_W = 4,
    parameter int F3_W = 4,
    parameter int F4_W = 4,
    parameter int F5_W = 4,
    parameter int F6_W = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DECONCAT_PARITY_EN
    input  logic        in_par,
    output logic        par_err,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_addr1,
    input  logic [1:0]  in_addr2,
    input  logic [1:0]  in_addr3,
    input  logic [1:0]  in_addr4,
    input  logic [1:0]  in_addr5,
    input  logic [2:0]  in_addr6,
    input  logic [4:0]  rd_addr1,
    input  logic [1:0]  rd_addr2,
    input  logic [1:0]  rd_addr3,
    input  logic [1:0]  rd_addr4,
    input  logic [1:0]  rd_addr5,
    input  logic [2:0]  rd_addr6,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done
);

    // Field k occupies in_data[Ok +: Fk_W]; field1 sits in the MSBs.
    localparam int O1 = 32 - F1_W;
    localparam int O2 = O1 - F2_W;
    localparam int O3 = O2 - F3_W;
    localparam int O4 = O3 - F4_W;
    localparam int O5 = O4 - F5_W;
    localparam int O6 = O5 - F6_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR1  = 3'd1,
        WR2  = 3'd2,
        WR3  = 3'd3,
        WR4  = 3'd4,
        WR5  = 3'd5,
        WR6  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  addr1_q, addr1_d;
    logic [1:0]  addr2_q, addr2_d;
    logic [1:0]  addr3_q, addr3_d;
    logic [1:0]  addr4_q, addr4_d;
    logic [1:0]  addr5_q, addr5_d;
    logic [2:0]  addr6_q, addr6_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        par_err_q, par_err_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [F1_W-1:0] bank1_q [32];
    logic [F1_W-1:0] bank1_d [32];
    logic [F2_W-1:0] bank2_q [4];
    logic [F2_W-1:0] bank2_d [4];
    logic [F3_W-1:0] bank3_q [4];
    logic [F3_W-1:0] bank3_d [4];
    logic [F4_W-1:0] bank4_q [4];
    logic [F4_W-1:0] bank4_d [4];
    logic [F5_W-1:0] bank5_q [4];
    logic [F5_W-1:0] bank5_d [4];
    logic [F6_W-1:0] bank6_q [8];
    logic [F6_W-1:0] bank6_d [8];

    logic accept;
    logic par_ok;

    assign accept = in_valid && in_ready_q && (state_q == IDLE);

`ifdef DECONCAT_PARITY_EN
    assign par_ok  = ((^in_data) == in_par);
    assign par_err = par_err_q;
`else
    assign par_ok  = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        addr3_d   = addr3_q;
        addr4_d   = addr4_q;
        addr5_d   = addr5_q;
        addr6_d   = addr6_q;
        done_d    = 1'b0;
        bank1_d   = bank1_q;
        bank2_d   = bank2_q;
        bank3_d   = bank3_q;
        bank4_d   = bank4_q;
        bank5_d   = bank5_q;
        bank6_d   = bank6_q;
        // A word with bad parity is dropped but still flags the sticky error.
        par_err_d = par_err_q | (accept & ~par_ok);

        case (state_q)
            IDLE: begin
                if (accept && par_ok) begin
                    data_d  = in_data;
                    addr1_d = in_addr1;
                    addr2_d = in_addr2;
                    addr3_d = in_addr3;
                    addr4_d = in_addr4;
                    addr5_d = in_addr5;
                    addr6_d = in_addr6;
                    state_d = WR1;
                end
            end
            WR1: begin
                bank1_d[addr1_q] = data_q[O1 +: F1_W];
                state_d          = WR2;
            end
            WR2: begin
                bank2_d[addr2_q] = data_q[O2 +: F2_W];
                state_d          = WR3;
            end
            WR3: begin
                bank3_d[addr3_q] = data_q[O3 +: F3_W];
                state_d          = WR4;
            end
            WR4: begin
                bank4_d[addr4_q] = data_q[O4 +: F4_W];
                state_d          = WR5;
            end
            WR5: begin
                bank5_d[addr5_q] = data_q[O5 +: F5_W];
                state_d          = WR6;
            end
            WR6: begin
                bank6_d[addr6_q] = data_q[O6 +: F6_W];
                state_d          = IDLE;
                done_d           = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);

        // Reads use the pre-edge bank contents, so a same-edge write returns the old value.
        rd_data_d = {bank1_q[rd_addr1], bank2_q[rd_addr2], bank3_q[rd_addr3],
                     bank4_q[rd_addr4], bank5_q[rd_addr5], bank6_q[rd_addr6]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            addr3_q    <= '0;
            addr4_q    <= '0;
            addr5_q    <= '0;
            addr6_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            par_err_q  <= 1'b0;
            rd_data_q  <= '0;
            bank1_q    <= '{default: '0};
            bank2_q    <= '{default: '0};
            bank3_q    <= '{default: '0};
            bank4_q    <= '{default: '0};
            bank5_q    <= '{default: '0};
            bank6_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            addr3_q    <= addr3_d;
            addr4_q    <= addr4_d;
            addr5_q    <= addr5_d;
            addr6_q    <= addr6_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            par_err_q  <= par_err_d;
            rd_data_q  <= rd_data_d;
            bank1_q    <= bank1_d;
            bank2_q    <= bank2_d;
            bank3_q    <= bank3_d;
            bank4_q    <= bank4_d;
            bank5_q    <= bank5_d;
            bank6_q    <= bank6_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;

endmodule
